// File: rtl/spi_rx_deserializer_pkg.sv
// Shared definitions for the SPI receive deserializer: default word width and FSM encoding.
package spi_rx_deserializer_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_DONE = 2'b10
    } spi_state_e;

endpackage

// File: rtl/spi_rx_deserializer_sync_edge.sv
// Multi-stage synchroniser for an idle-low async input plus a one-clk rising-edge strobe.
module spi_rx_deserializer_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one delay flop used for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI receive deserializer: rebuilds words from sclk/ss_n/mosi and offers them on valid/ready.
module spi_rx_deserializer
    import spi_rx_deserializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] ss_n_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   ss_n_s;
    logic                   mosi_s;
    logic                   sclk_rise;

    spi_state_e             state_q,     state_d;
    logic [DATA_WIDTH-1:0]  shift_q,     shift_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   overrun_q,   overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0]  shift_in;

    spi_rx_deserializer_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .rise_c (sclk_rise)
    );

    // ss_n and mosi chains match the sclk depth so data stays aligned with the edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_n_sync_q <= '1;
            mosi_sync_q <= '0;
        end else begin
            ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign ss_n_s = ss_n_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign shift_in = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, shift_q[DATA_WIDTH-1:1]};

    // State, shift register, bit counter, output buffer and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: frame tracking, bit assembly and single-entry output buffer
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                if (!ss_n_s) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                // Deselect takes priority over a coincident sclk edge
                if (ss_n_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ss_n_s ? ST_IDLE : ST_RECV;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                shift_d   = '0;
            end
        endcase

        if (state_q == ST_DONE) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
